vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 141 ++++++++++++++
 tb/tb_vga_timing.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing -- raster timing generator for VGA-style displays.
//
// Walks a pixel position (x, y) across an H_TOTAL x V_TOTAL raster, one step
// per clk in which pix_en is high, and produces the sync, visible-area and
// strobe signals that pixel/overlay generators need. All outputs are
// registered and cycle-aligned with x/y.
//
// Optional feature macro: VGA_FRAME_COUNTER_EN
//   defined   -> frame_cnt is an 8-bit counter of completed frames
//   undefined -> frame_cnt is tied to 0 and no counter register exists
//
// Ports
//   clk          in   single clock, all state updates on its rising edge
//   rst_n        in   synchronous active-low reset, dominates pix_en
//   pix_en       in   pixel-rate clock enable
//   x            out  [9:0] current horizontal position
//   y            out  [9:0] current vertical position
//   active       out  1 while (x, y) lies in the visible area
//   hsync        out  active-low horizontal sync pulse
//   vsync        out  active-low vertical sync pulse
//   line_start   out  1-clk strobe when x returns to 0
//   frame_start  out  1-clk strobe when (x, y) returns to (0, 0)
//   frame_cnt    out  [7:0] frame counter (see macro above)
// ---------------------------------------------------------------------------
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q;
  logic       frame_start_q;
  logic       wrap_x;
  logic       wrap_y;

  // Wrap events only exist on enabled cycles, so the strobes they produce are
  // automatically 0 whenever pix_en is low.
  assign wrap_x = pix_en && (x_q == X_LAST);
  assign wrap_y = wrap_x && (y_q == Y_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      x_d = wrap_x ? 10'd0 : x_q + 10'd1;
      if (wrap_x) begin
        y_d = wrap_y ? 10'd0 : y_q + 10'd1;
      end
    end
  end

  // Decoding the next-state position lets the registered flags land in the
  // same cycle as the x/y they describe. With pix_en low x_d/y_d equal the
  // current position, so the flags hold naturally.
  always_comb begin
    active_d = (x_d < X_VIS) && (y_d < Y_VIS);
    hsync_d  = !((x_d >= HS_START) && (x_d < HS_END));
    vsync_d  = !((y_d >= VS_START) && (y_d < VS_END));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      active_q      <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= wrap_x;
      frame_start_q <= wrap_y;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_cnt_q;

  // Advances on the same edge that raises frame_start; 8-bit rollover wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (wrap_y) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

  // Small raster for the scoreboarded instance so that 256+ frames fit:
  // H: 8 visible + 2 fp + 3 sync + 2 bp = 15, hsync low at x=10..12
  // V: 4 visible + 1 fp + 2 sync + 1 bp = 8,  vsync low at y=5..6
  // One frame = 120 enabled clks, 32 of them visible, 30 with vsync low.
  localparam int HT = 15;
  localparam int VT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [9:0] x, y;
  logic       active, hsync, vsync, line_start, frame_start;
  logic [7:0] frame_cnt;

  logic       pen_def = 1'b1;
  logic [9:0] dx, dy;
  logic       dactive, dhsync, dvsync, dline_start, dframe_start;
  logic [7:0] dframe_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  // Default 640x480 timing, always enabled, checked at hand-computed points.
  vga_timing dut_def (
    .clk(clk), .rst_n(rst_n), .pix_en(pen_def),
    .x(dx), .y(dy), .active(dactive), .hsync(dhsync), .vsync(dvsync),
    .line_start(dline_start), .frame_start(dframe_start), .frame_cnt(dframe_cnt)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  obs_t exp_q[$];

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // ---------------- reference model (small raster) ----------------
  int mx, my, mfc;
  bit mls, mfs;

  function automatic obs_t model_obs();
    obs_t o;
    o.x   = 10'(mx);
    o.y   = 10'(my);
    o.act = (mx < 8) && (my < 4);
    o.hs  = !(mx >= 10 && mx <= 12);
    o.vs  = !(my >= 5 && my <= 6);
    o.ls  = mls;
    o.fs  = mfs;
    o.fc  = 8'(mfc);
    return o;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show after the
  // following rising edge.
  task automatic step(input bit pen, input bit rstn);
    @(negedge clk);
    pix_en = pen;
    rst_n  = rstn;
    mls = 1'b0;
    mfs = 1'b0;
    if (!rstn) begin
      mx = 0; my = 0; mfc = 0;
    end else if (pen) begin
      if (mx == HT - 1) begin
        mx  = 0;
        mls = 1'b1;
        if (my == VT - 1) begin
          my  = 0;
          mfs = 1'b1;
`ifdef VGA_FRAME_COUNTER_EN
          mfc = (mfc + 1) % 256;
`endif
        end else begin
          my = my + 1;
        end
      end else begin
        mx = mx + 1;
      end
    end
    exp_q.push_back(model_obs());
  endtask

  // ---------------- monitor / scoreboard ----------------
  int en_cnt, act_cnt, vs_cnt, hs_cnt;
  int fc_wraps = 0;
  int fc_max = 0;
  logic [7:0] prev_fc = 8'd0;

  always begin
    obs_t e, a;
    bit pen_s, rst_s;
    @(posedge clk);
    #1;
    pen_s = pix_en;
    rst_s = rst_n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {x, y, active, hsync, vsync, line_start, frame_start, frame_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                 $time, a.x, a.y, a.act, a.hs, a.vs, a.ls, a.fs, a.fc,
                 e.x, e.y, e.act, e.hs, e.vs, e.ls, e.fs, e.fc);
      end
      // Run-length checks with hand-computed per-line / per-frame totals.
      if (!rst_s) begin
        en_cnt = 0; act_cnt = 0; vs_cnt = 0; hs_cnt = 0;
      end else if (pen_s) begin
        en_cnt++;
        if (active) act_cnt++;
        if (!vsync) vs_cnt++;
        if (!hsync) hs_cnt++;
        if (line_start) begin
          chk("hsync_low_per_line", hs_cnt, 3);
          hs_cnt = 0;
        end
        if (frame_start) begin
          chk("clks_per_frame", en_cnt, 120);
          chk("active_per_frame", act_cnt, 32);
          chk("vsync_low_per_frame", vs_cnt, 30);
          en_cnt = 0; act_cnt = 0; vs_cnt = 0;
        end
      end
      if (rst_s && prev_fc == 8'd255 && frame_cnt == 8'd0) fc_wraps++;
      if (int'(frame_cnt) > fc_max) fc_max = int'(frame_cnt);
      prev_fc = frame_cnt;
    end
  end

  // ---------------- default-timing directed checks ----------------
  int def_cyc = 0;
  int def_hs = 0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      def_cyc = 0;
      def_hs  = 0;
    end else begin
      def_cyc++;
      if (def_cyc < 800 && !dhsync) def_hs++;
    end
    if (exp_q.size() > 0 || def_cyc > 0) begin
      case (def_cyc)
        0: begin
          if (!rst_n && $time > 20) begin
            chk("def_reset_x", int'(dx), 0);
            chk("def_reset_active", int'(dactive), 1);
            chk("def_reset_hsync", int'(dhsync), 1);
            chk("def_reset_vsync", int'(dvsync), 1);
          end
        end
        639: chk("def_active_x639", int'(dactive), 1);
        640: chk("def_active_x640", int'(dactive), 0);
        655: chk("def_hsync_x655", int'(dhsync), 1);
        656: chk("def_hsync_x656", int'(dhsync), 0);
        751: chk("def_hsync_x751", int'(dhsync), 0);
        752: chk("def_hsync_x752", int'(dhsync), 1);
        799: begin
          chk("def_x_last", int'(dx), 799);
          chk("def_y_line0", int'(dy), 0);
          chk("def_ls_x799", int'(dline_start), 0);
        end
        800: begin
          chk("def_x_wrap", int'(dx), 0);
          chk("def_y_line1", int'(dy), 1);
          chk("def_ls_wrap", int'(dline_start), 1);
          chk("def_fs_line1", int'(dframe_start), 0);
          chk("def_hsync_run", def_hs, 96);
        end
        801: begin
          chk("def_ls_width", int'(dline_start), 0);
          chk("def_x_after", int'(dx), 1);
        end
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
    mx = 0; my = 0; mfc = 0; mls = 1'b0; mfs = 1'b0;

    // Reset with pix_en low, then with pix_en high (reset dominates).
    repeat (2) step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Continuous run: covers the default-timing instance's first line too.
    repeat (1800) step(1'b1, 1'b1);

    // pix_en toggling every other clk.
    for (int i = 0; i < 400; i++) step(i[0], 1'b1);

    // Mid-frame reset at (5,3), asserted together with pix_en.
    for (int i = 0; i < 200 && !(mx == 5 && my == 3); i++) step(1'b1, 1'b1);
    chk("reached_mid_frame", mx * 100 + my, 503);
    step(1'b1, 1'b0);

    // 257 frames and a bit: frame_cnt must roll over exactly once.
    repeat (257 * 120 + 10) step(1'b1, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
`ifdef VGA_FRAME_COUNTER_EN
    chk("frame_cnt_wraps", fc_wraps, 1);
`else
    chk("frame_cnt_max", fc_max, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
